// File: rtl/mem_seq_pkg.sv
// Shared state encoding and default widths for the memory access sequencer.
package mem_seq_pkg;

  localparam int DEFAULT_DATAWIDTH_BUS  = 32;
  localparam int DEFAULT_DATAWIDTH_ADDR = 32;
  localparam int DEFAULT_TIMEOUT_CYCLES = 255;
  localparam int DEFAULT_TIMEOUT_WIDTH  = 8;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_DONE = 3'd2,
    S_GAP  = 3'd3,
    S_ERR  = 3'd4
  } state_e;

  function automatic logic is_busy(input state_e s);
    return (s == S_REQ) || (s == S_DONE) || (s == S_GAP);
  endfunction

endpackage

// File: rtl/mem_access_sequencer_if.sv
// MIR/datapath/main-memory signal bundle; master = sequencer, slave = surrounding system.
interface mem_access_sequencer_if #(
  parameter int DATAWIDTH_BUS  = 32,
  parameter int DATAWIDTH_ADDR = 32
);
  logic                      Mem_Access_Sequencer_RD;
  logic                      Mem_Access_Sequencer_WR;
  logic [DATAWIDTH_ADDR-1:0] Mem_Access_Sequencer_ADDR_InBUS;
  logic [DATAWIDTH_BUS-1:0]  Mem_Access_Sequencer_WDATA_InBUS;
  logic                      Mem_Access_Sequencer_Mem_ACK;
  logic [DATAWIDTH_BUS-1:0]  Mem_Access_Sequencer_Mem_RDATA;
  logic                      Mem_Access_Sequencer_Mem_REQ;
  logic                      Mem_Access_Sequencer_Mem_WE;
  logic [DATAWIDTH_ADDR-1:0] Mem_Access_Sequencer_Mem_ADDR;
  logic [DATAWIDTH_BUS-1:0]  Mem_Access_Sequencer_Mem_WDATA;
  logic [DATAWIDTH_BUS-1:0]  Mem_Access_Sequencer_RDATA_OutBUS;
  logic                      Mem_Access_Sequencer_ACK;
  logic                      Mem_Access_Sequencer_Busy;
  logic                      Mem_Access_Sequencer_Error;

  modport master (
    input  Mem_Access_Sequencer_RD, Mem_Access_Sequencer_WR,
           Mem_Access_Sequencer_ADDR_InBUS, Mem_Access_Sequencer_WDATA_InBUS,
           Mem_Access_Sequencer_Mem_ACK, Mem_Access_Sequencer_Mem_RDATA,
    output Mem_Access_Sequencer_Mem_REQ, Mem_Access_Sequencer_Mem_WE,
           Mem_Access_Sequencer_Mem_ADDR, Mem_Access_Sequencer_Mem_WDATA,
           Mem_Access_Sequencer_RDATA_OutBUS, Mem_Access_Sequencer_ACK,
           Mem_Access_Sequencer_Busy, Mem_Access_Sequencer_Error
  );

  modport slave (
    output Mem_Access_Sequencer_RD, Mem_Access_Sequencer_WR,
           Mem_Access_Sequencer_ADDR_InBUS, Mem_Access_Sequencer_WDATA_InBUS,
           Mem_Access_Sequencer_Mem_ACK, Mem_Access_Sequencer_Mem_RDATA,
    input  Mem_Access_Sequencer_Mem_REQ, Mem_Access_Sequencer_Mem_WE,
           Mem_Access_Sequencer_Mem_ADDR, Mem_Access_Sequencer_Mem_WDATA,
           Mem_Access_Sequencer_RDATA_OutBUS, Mem_Access_Sequencer_ACK,
           Mem_Access_Sequencer_Busy, Mem_Access_Sequencer_Error
  );
endinterface

// File: rtl/mem_seq_timeout_counter.sv
// REQ-phase watchdog counter; only compiled when MEM_SEQ_TIMEOUT_EN is defined.
`ifdef MEM_SEQ_TIMEOUT_EN
module mem_seq_timeout_counter #(
  parameter int LIMIT = 255,
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);
  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && !o_expired) begin
      r_count <= r_count + 1'b1;
    end
  end

  // Fires on the LIMIT-th consecutive enabled cycle.
  assign o_expired = i_enable && (r_count == WIDTH'(LIMIT - 1));
endmodule
`endif

// File: rtl/mem_access_sequencer.sv
// One main-memory transaction per microinstruction: REQ/ACK handshake, read capture, done pulse.
// Optional REQ watchdog enabled by defining MEM_SEQ_TIMEOUT_EN.
module mem_access_sequencer
  import mem_seq_pkg::*;
#(
  parameter int DATAWIDTH_BUS  = DEFAULT_DATAWIDTH_BUS,
  parameter int DATAWIDTH_ADDR = DEFAULT_DATAWIDTH_ADDR,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int TIMEOUT_WIDTH  = DEFAULT_TIMEOUT_WIDTH
) (
  input  logic                  Mem_Access_Sequencer_CLOCK_50,
  input  logic                  Mem_Access_Sequencer_RESET_InLow,
  input  logic                  Mem_Access_Sequencer_clear_InLow,
  mem_access_sequencer_if.master bus
);
  state_e                    r_state, w_state_next;
  logic [DATAWIDTH_ADDR-1:0] r_addr;
  logic [DATAWIDTH_BUS-1:0]  r_wdata, r_rdata;
  logic                      r_we, r_req, r_ack, r_busy, r_err;
  logic                      w_rd, w_wr, w_mem_ack, w_latch, w_capture, w_timeout;

  assign w_rd      = bus.Mem_Access_Sequencer_RD;
  assign w_wr      = bus.Mem_Access_Sequencer_WR;
  assign w_mem_ack = bus.Mem_Access_Sequencer_Mem_ACK;

`ifdef MEM_SEQ_TIMEOUT_EN
  mem_seq_timeout_counter #(
    .LIMIT (TIMEOUT_CYCLES),
    .WIDTH (TIMEOUT_WIDTH)
  ) u_timeout (
    .clk       (Mem_Access_Sequencer_CLOCK_50),
    .rst_n     (Mem_Access_Sequencer_RESET_InLow),
    .i_clear   (r_state != S_REQ),
    .i_enable  (r_state == S_REQ),
    .o_expired (w_timeout)
  );
`else
  logic [TIMEOUT_WIDTH-1:0] w_unused_timeout;
  assign w_unused_timeout = TIMEOUT_WIDTH'(TIMEOUT_CYCLES);
  assign w_timeout        = 1'b0;
`endif

  always_comb begin
    w_state_next = r_state;
    w_latch      = 1'b0;
    w_capture    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_rd && w_wr) begin
          w_state_next = S_ERR;
        end else if (w_rd ^ w_wr) begin
          w_state_next = S_REQ;
          w_latch      = 1'b1;
        end
      end
      // Memory ACK takes priority over a simultaneous timeout.
      S_REQ: begin
        if (w_mem_ack) begin
          w_state_next = S_DONE;
          w_capture    = !r_we;
        end else if (w_timeout) begin
          w_state_next = S_ERR;
        end
      end
      S_DONE:  w_state_next = S_GAP;
      S_GAP:   w_state_next = S_IDLE;
      S_ERR:   if (!Mem_Access_Sequencer_clear_InLow) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Mem_Access_Sequencer_CLOCK_50 or negedge Mem_Access_Sequencer_RESET_InLow) begin
    if (!Mem_Access_Sequencer_RESET_InLow) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_we    <= 1'b0;
      r_req   <= 1'b0;
      r_ack   <= 1'b0;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_latch) begin
        r_addr  <= bus.Mem_Access_Sequencer_ADDR_InBUS;
        r_wdata <= bus.Mem_Access_Sequencer_WDATA_InBUS;
        r_we    <= w_wr;
      end
      if (w_capture) r_rdata <= bus.Mem_Access_Sequencer_Mem_RDATA;
      r_req  <= (w_state_next == S_REQ);
      r_ack  <= (w_state_next == S_DONE);
      r_busy <= is_busy(w_state_next);
      r_err  <= (w_state_next == S_ERR);
    end
  end

  assign bus.Mem_Access_Sequencer_Mem_REQ     = r_req;
  assign bus.Mem_Access_Sequencer_Mem_WE      = r_we;
  assign bus.Mem_Access_Sequencer_Mem_ADDR    = r_addr;
  assign bus.Mem_Access_Sequencer_Mem_WDATA   = r_wdata;
  assign bus.Mem_Access_Sequencer_RDATA_OutBUS = r_rdata;
  assign bus.Mem_Access_Sequencer_ACK         = r_ack;
  assign bus.Mem_Access_Sequencer_Busy        = r_busy;
  assign bus.Mem_Access_Sequencer_Error       = r_err;
endmodule
